// File: rtl/falu_pkg.sv
// falu_pkg: shared widths and pipeline entry types for the FP adder close path.
package falu_pkg;
  localparam int SIG_W   = 28;
  localparam int EXP_W   = 8;
  localparam int SHAMT_W = 5;
  typedef struct packed {
    logic [SIG_W-1:0]   sum;
    logic [SHAMT_W-1:0] pred;
    logic [EXP_W-1:0]   expnt;
    logic               sign;
  } lop_t;
  typedef struct packed {
    logic [SIG_W-1:0] mant;
    logic [EXP_W-1:0] expnt;
    logic             sign;
    logic             zero;
    logic             denorm;
  } norm_t;
endpackage

// File: rtl/pa_fadd_norm_shf_s.sv
// pa_fadd_norm_shf_s: leading-one shift with 1-bit correction and denormal clamp.
module pa_fadd_norm_shf_s
  import falu_pkg::*;
(
  input  logic [SIG_W-1:0]   i_sum,
  input  logic [SHAMT_W-1:0] i_pred,
  input  logic [EXP_W-1:0]   i_expnt,
  input  logic               i_sign,
  output logic [SIG_W-1:0]   o_mant,
  output logic [EXP_W-1:0]   o_expnt,
  output logic               o_sign,
  output logic               o_zero,
  output logic               o_denorm
);
  logic [SHAMT_W-1:0] w_pred;
  logic [SHAMT_W-1:0] w_idx;
  logic [EXP_W-1:0]   w_shamt;
  logic [EXP_W-1:0]   w_shf;
  logic               w_nz;
  logic               w_big;
  always_comb begin
    w_pred   = (i_pred > SHAMT_W'(SIG_W-1)) ? SHAMT_W'(SIG_W-1) : i_pred;
    w_idx    = SHAMT_W'(SIG_W-1) - w_pred;
    // bit landing at the MSB after the coarse shift decides the correction
    w_shamt  = {{(EXP_W-SHAMT_W){1'b0}}, w_pred} + (i_sum[w_idx] ? EXP_W'(0) : EXP_W'(1));
    w_nz     = |i_sum;
    w_big    = i_expnt > w_shamt;
    w_shf    = ~w_nz ? '0 : w_big ? w_shamt : (i_expnt == '0) ? '0 : i_expnt - EXP_W'(1);
    o_mant   = i_sum << w_shf;
    o_expnt  = (w_nz & w_big) ? i_expnt - w_shamt : '0;
    o_sign   = i_sign & w_nz;
    o_zero   = ~w_nz;
    o_denorm = w_nz & ~w_big;
  end
endmodule

// File: rtl/pa_fadd_norm_s2_s.sv
// pa_fadd_norm_s2_s: two-stage close-path normalizer (capture, shift/correct) with valid/ready flow control.
module pa_fadd_norm_s2_s
  import falu_pkg::*;
(
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               norm_flush,
  input  logic               lop_vld,
  output logic               lop_rdy,
  input  logic [SIG_W-1:0]   lop_sum,
  input  logic [SHAMT_W-1:0] lop_ff1_pred,
  input  logic [EXP_W-1:0]   lop_expnt,
  input  logic               lop_sign,
  output logic               norm_vld,
  input  logic               norm_rdy,
  output logic [SIG_W-1:0]   norm_mant,
  output logic [EXP_W-1:0]   norm_expnt,
  output logic               norm_sign,
  output logic               norm_zero,
  output logic               norm_denorm
);
  lop_t             r_s1;
  norm_t            r_s2;
  logic             r_s1_vld;
  logic             r_s2_vld;
  logic             w_s1_ld;
  logic             w_s2_ld;
  logic [SIG_W-1:0] w_mant;
  logic [EXP_W-1:0] w_expnt;
  logic             w_sign;
  logic             w_zero;
  logic             w_denorm;
  always_comb begin
    w_s2_ld = r_s1_vld & (~r_s2_vld | norm_rdy);
    lop_rdy = ~r_s1_vld | w_s2_ld | norm_flush;
    w_s1_ld = lop_vld & lop_rdy & ~norm_flush;
  end
  pa_fadd_norm_shf_s u_shf (
    .i_sum    (r_s1.sum),
    .i_pred   (r_s1.pred),
    .i_expnt  (r_s1.expnt),
    .i_sign   (r_s1.sign),
    .o_mant   (w_mant),
    .o_expnt  (w_expnt),
    .o_sign   (w_sign),
    .o_zero   (w_zero),
    .o_denorm (w_denorm)
  );
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s1     <= '0;
      r_s2     <= '0;
    end else begin
      r_s1_vld <= ~norm_flush & (w_s1_ld | (r_s1_vld & ~w_s2_ld));
      r_s2_vld <= ~norm_flush & (w_s2_ld | (r_s2_vld & ~norm_rdy));
      if (w_s1_ld) r_s1 <= '{sum: lop_sum, pred: lop_ff1_pred, expnt: lop_expnt, sign: lop_sign};
      if (w_s2_ld & ~norm_flush) r_s2 <= '{mant: w_mant, expnt: w_expnt, sign: w_sign, zero: w_zero, denorm: w_denorm};
    end
  end
  always_comb begin
    norm_vld    = r_s2_vld;
    norm_mant   = r_s2.mant;
    norm_expnt  = r_s2.expnt;
    norm_sign   = r_s2.sign;
    norm_zero   = r_s2.zero;
    norm_denorm = r_s2.denorm;
  end
endmodule

// File: tb/tb_pa_fadd_norm_s2_s.sv
// tb_pa_fadd_norm_s2_s: randomized and directed checks of the normalizer against a leading-zero-count model.
module tb_pa_fadd_norm_s2_s;
  typedef logic [38:0] res_t;
  typedef struct {
    logic [27:0] sum;
    logic [4:0]  pred;
    logic [7:0]  expnt;
    logic        sign;
  } in_t;
  logic        clk = 1'b0;
  logic        cpurst = 1'b0;
  logic        norm_flush = 1'b0;
  logic        lop_vld = 1'b0;
  logic        lop_rdy;
  logic [27:0] lop_sum = '0;
  logic [4:0]  lop_ff1_pred = '0;
  logic [7:0]  lop_expnt = '0;
  logic        lop_sign = 1'b0;
  logic        norm_vld;
  logic        norm_rdy = 1'b1;
  logic [27:0] norm_mant;
  logic [7:0]  norm_expnt;
  logic        norm_sign;
  logic        norm_zero;
  logic        norm_denorm;
  int          checks = 0;
  int          errors = 0;
  res_t        exp_q[$];
  always #5 clk = ~clk;
  pa_fadd_norm_s2_s dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .norm_flush     (norm_flush),
    .lop_vld        (lop_vld),
    .lop_rdy        (lop_rdy),
    .lop_sum        (lop_sum),
    .lop_ff1_pred   (lop_ff1_pred),
    .lop_expnt      (lop_expnt),
    .lop_sign       (lop_sign),
    .norm_vld       (norm_vld),
    .norm_rdy       (norm_rdy),
    .norm_mant      (norm_mant),
    .norm_expnt     (norm_expnt),
    .norm_sign      (norm_sign),
    .norm_zero      (norm_zero),
    .norm_denorm    (norm_denorm)
  );
  function automatic res_t obs();
    return {norm_mant, norm_expnt, norm_sign, norm_zero, norm_denorm};
  endfunction
  // reference: true leading-zero count, then exponent-limited shift
  function automatic res_t model(input in_t x);
    int          lz;
    logic [27:0] m;
    logic [7:0]  e;
    if (x.sum == 0) return {28'd0, 8'd0, 1'b0, 1'b1, 1'b0};
    lz = 0;
    while (x.sum[27-lz] == 1'b0) lz++;
    if (int'(x.expnt) > lz) begin
      m = x.sum << lz;
      e = x.expnt - 8'(lz);
      return {m, e, x.sign, 1'b0, 1'b0};
    end
    m = (x.expnt == 0) ? x.sum : x.sum << (x.expnt - 1);
    return {m, 8'd0, x.sign, 1'b0, 1'b1};
  endfunction
  function automatic in_t gen();
    in_t x;
    int  pos;
    int  lz;
    pos = $urandom_range(0, 28);
    if (pos == 28) x.sum = '0;
    else x.sum = (28'd1 << pos) | (28'($urandom) & ((28'd1 << pos) - 28'd1));
    lz = 27 - pos;
    if (pos == 28) x.pred = 5'($urandom);
    else if (lz == 27 && $urandom_range(0, 1) == 1) x.pred = 5'($urandom_range(27, 31));
    else x.pred = 5'((lz > 0 && $urandom_range(0, 1) == 1) ? lz - 1 : lz);
    x.expnt = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
    x.sign = 1'($urandom);
    return x;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input in_t x);
    lop_vld = v;
    lop_sum = x.sum;
    lop_ff1_pred = x.pred;
    lop_expnt = x.expnt;
    lop_sign = x.sign;
  endtask
  task automatic test_reset();
    in_t x;
    x = gen();
    cpurst = 1'b1;
    drive(1'b0, x);
    tick();
    tick();
    cpurst = 1'b0;
    norm_rdy = 1'b0;
    drive(1'b1, x);
    tick();
    drive(1'b1, gen());
    tick();
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    drive(1'b0, x);
    #1;
    checks++;
    if (norm_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", norm_vld); end
    checks++;
    if (obs() !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs()); end
    checks++;
    if (lop_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", lop_rdy); end
    norm_rdy = 1'b1;
    tick();
  endtask
  task automatic test_directed();
    in_t  v[7];
    res_t r[7];
    v[0] = '{28'h0400000, 5'd5, 8'd100, 1'b0};  r[0] = {28'h8000000, 8'd95, 3'b000};
    v[1] = '{28'h0200000, 5'd5, 8'd100, 1'b1};  r[1] = {28'h8000000, 8'd94, 3'b100};
    v[2] = '{28'h0000100, 5'd19, 8'd10, 1'b0};  r[2] = {28'h0020000, 8'd0, 3'b001};
    v[3] = '{28'h0000000, 5'd9, 8'd50, 1'b1};   r[3] = {28'h0000000, 8'd0, 3'b010};
    v[4] = '{28'h0000001, 5'd30, 8'd200, 1'b0}; r[4] = {28'h8000000, 8'd173, 3'b000};
    v[5] = '{28'h1234567, 5'd3, 8'd0, 1'b1};    r[5] = {28'h1234567, 8'd0, 3'b101};
    v[6] = '{28'h0400000, 5'd5, 8'd6, 1'b0};    r[6] = {28'h8000000, 8'd1, 3'b000};
    norm_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, v[i]);
      #1;
      checks++;
      if (lop_rdy !== 1'b1) begin errors++; $display("FAIL dir%0d_rdy got %b want 1", i, lop_rdy); end
      tick();
      lop_vld = 1'b0;
      #1;
      checks++;
      if (norm_vld !== 1'b0) begin errors++; $display("FAIL dir%0d_early got vld %b want 0", i, norm_vld); end
      tick();
      checks++;
      if (norm_vld !== 1'b1 || obs() !== r[i])
        begin errors++; $display("FAIL dir%0d_result got vld %b res %h want 1 %h", i, norm_vld, obs(), r[i]); end
      tick();
    end
  endtask
  task automatic test_back_to_back();
    in_t  v[4];
    res_t snap;
    res_t e;
    int   idx;
    int   got;
    for (int i = 0; i < 4; i++) v[i] = gen();
    idx = 0;
    got = 0;
    snap = '0;
    exp_q.delete();
    for (int c = 0; c < 40 && got < 4; c++) begin
      norm_rdy = (c >= 5);
      if (idx < 4) drive(1'b1, v[idx]);
      else lop_vld = 1'b0;
      #1;
      if (c == 2) begin
        checks++;
        if (lop_rdy !== 1'b0 || idx != 2)
          begin errors++; $display("FAIL b2b_stall got rdy %b accepted %0d want 0 2", lop_rdy, idx); end
        snap = obs();
      end
      if (c == 4) begin
        checks++;
        if (norm_vld !== 1'b1 || obs() !== snap || snap !== model(v[0]))
          begin errors++; $display("FAIL b2b_hold got vld %b res %h want 1 %h", norm_vld, obs(), model(v[0])); end
      end
      if (norm_vld && norm_rdy) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (obs() !== e) begin errors++; $display("FAIL b2b_out%0d got %h want %h", got, obs(), e); end
        got++;
      end
      if (lop_vld && lop_rdy) begin
        exp_q.push_back(model(v[idx]));
        idx++;
      end
      tick();
    end
    lop_vld = 1'b0;
    #1;
    checks++;
    if (got != 4 || norm_vld !== 1'b0)
      begin errors++; $display("FAIL b2b_count got %0d extra vld %b want 4 0", got, norm_vld); end
  endtask
  task automatic test_random();
    in_t  x;
    res_t e;
    res_t prev;
    logic held;
    exp_q.delete();
    held = 1'b0;
    prev = '0;
    for (int c = 0; c < 400; c++) begin
      x = gen();
      norm_rdy = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, x);
      #1;
      if (held) begin
        checks++;
        if (norm_vld !== 1'b1 || obs() !== prev)
          begin errors++; $display("FAIL rand_hold c%0d got %b %h want 1 %h", c, norm_vld, obs(), prev); end
      end
      if (norm_vld && norm_rdy) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (obs() !== e) begin errors++; $display("FAIL rand_out c%0d got %h want %h", c, obs(), e); end
      end
      held = norm_vld && !norm_rdy;
      prev = obs();
      if (lop_vld && lop_rdy) exp_q.push_back(model(x));
      tick();
    end
    lop_vld = 1'b0;
    norm_rdy = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      #1;
      if (norm_vld) begin
        checks++;
        e = exp_q.pop_front();
        if (obs() !== e) begin errors++; $display("FAIL rand_drain got %h want %h", obs(), e); end
      end
      tick();
    end
    #1;
    checks++;
    if (exp_q.size() != 0 || norm_vld !== 1'b0)
      begin errors++; $display("FAIL rand_left got %0d pending vld %b want 0 0", exp_q.size(), norm_vld); end
  endtask
  task automatic test_flush_reset();
    logic seen;
    norm_rdy = 1'b0;
    drive(1'b1, gen());
    tick();
    drive(1'b1, gen());
    tick();
    drive(1'b1, gen());
    #1;
    checks++;
    if (norm_vld !== 1'b1 || lop_rdy !== 1'b0)
      begin errors++; $display("FAIL flush_full got vld %b rdy %b want 1 0", norm_vld, lop_rdy); end
    norm_flush = 1'b1;
    #1;
    checks++;
    if (lop_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy got %b want 1", lop_rdy); end
    tick();
    norm_flush = 1'b0;
    lop_vld = 1'b0;
    norm_rdy = 1'b1;
    #1;
    checks++;
    if (norm_vld !== 1'b0) begin errors++; $display("FAIL flush_vld got %b want 0", norm_vld); end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen |= norm_vld;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_stale got %b want 0", seen); end
    drive(1'b1, gen());
    tick();
    drive(1'b1, gen());
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    lop_vld = 1'b0;
    #1;
    checks++;
    if (norm_vld !== 1'b0 || lop_rdy !== 1'b1)
      begin errors++; $display("FAIL rst_mid got vld %b rdy %b want 0 1", norm_vld, lop_rdy); end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen |= norm_vld;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_stale got %b want 0", seen); end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
